// File: rtl/tug_playfield.sv
// tug_playfield: tug-of-war game core that walks a lit LED, scores rounds and latches the match winner
module tug_playfield #(
  parameter int N_POS = 9,
  parameter int HOLD_CYCLES = 4,
  parameter int SCORE_MAX = 7,
  localparam int SW = $clog2(SCORE_MAX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             L,
  input  logic             R,
  output logic [N_POS-1:0] leds,
  output logic [1:0]       winner,
  output logic [SW-1:0]    score_l,
  output logic [SW-1:0]    score_r,
  output logic             game_over
);
  localparam int C = (N_POS - 1) / 2;
  localparam int PW = $clog2(N_POS);
  localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [N_POS-1:0] LED_C = N_POS'(1) << C;
  localparam logic [N_POS-1:0] LED_L = N_POS'(1) << (N_POS - 1);
  localparam logic [N_POS-1:0] LED_R = N_POS'(1);
  localparam logic [SW-1:0] SMAX = SW'(SCORE_MAX);
  typedef enum logic [1:0] {PLAY, WIN, OVER} state_t;
  state_t r_state;
  logic [PW-1:0] r_pos;
  logic [CW-1:0] r_cnt;
  logic [N_POS-1:0] r_leds;
  logic [1:0] r_winner;
  logic [SW-1:0] r_score_l, r_score_r;
  logic r_over;
  logic w_l, w_r, w_at_l, w_at_r;
  logic [SW-1:0] w_sl_inc, w_sr_inc;
  assign w_l = L & ~R;
  assign w_r = R & ~L;
  assign w_at_l = r_pos == PW'(N_POS - 1);
  assign w_at_r = r_pos == '0;
  assign w_sl_inc = r_score_l + 1'b1;
  assign w_sr_inc = r_score_r + 1'b1;
  assign leds = r_leds;
  assign winner = r_winner;
  assign score_l = r_score_l;
  assign score_r = r_score_r;
  assign game_over = r_over;
  // game FSM: moves the light in PLAY, holds the round result in WIN, freezes in OVER
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= PLAY;
      r_pos <= PW'(C);
      r_leds <= LED_C;
      r_winner <= 2'b00;
      r_score_l <= '0;
      r_score_r <= '0;
      r_over <= 1'b0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        PLAY: begin
          if (w_l && w_at_l) begin
            r_score_l <= w_sl_inc;
            r_winner <= 2'b10;
            r_leds <= LED_L;
            r_cnt <= CW'(HOLD_CYCLES - 1);
            r_state <= (w_sl_inc == SMAX) ? OVER : WIN;
            r_over <= w_sl_inc == SMAX;
          end else if (w_l) begin
            r_pos <= r_pos + 1'b1;
            r_leds <= r_leds << 1;
          end else if (w_r && w_at_r) begin
            r_score_r <= w_sr_inc;
            r_winner <= 2'b01;
            r_leds <= LED_R;
            r_cnt <= CW'(HOLD_CYCLES - 1);
            r_state <= (w_sr_inc == SMAX) ? OVER : WIN;
            r_over <= w_sr_inc == SMAX;
          end else if (w_r) begin
            r_pos <= r_pos - 1'b1;
            r_leds <= r_leds >> 1;
          end
        end
        WIN: begin
          if (r_cnt == '0) begin
            r_state <= PLAY;
            r_pos <= PW'(C);
            r_leds <= LED_C;
            r_winner <= 2'b00;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_tug_playfield.sv
// tb_tug_playfield: scoreboard bench for tug_playfield with directed test-plan checks
module tb_tug_playfield;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic L = 1'b0;
  logic R = 1'b0;
  logic [8:0] leds;
  logic [1:0] winner;
  logic [2:0] score_l, score_r;
  logic game_over;
  int total = 0;
  int bad = 0;
  typedef struct packed {
    logic [8:0] leds;
    logic [1:0] w;
    logic [2:0] sl;
    logic [2:0] sr;
    logic go;
  } exp_t;
  exp_t q[$];
  int m_st = 0, m_pos = 4, m_cnt = 0, m_sl = 0, m_sr = 0, m_w = 0;

  tug_playfield dut (
    .clk(clk), .reset(reset), .L(L), .R(R), .leds(leds), .winner(winner),
    .score_l(score_l), .score_r(score_r), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic l, input logic r, input logic rs);
    exp_t e;
    if (rs) begin
      m_st = 0; m_pos = 4; m_cnt = 0; m_sl = 0; m_sr = 0; m_w = 0;
    end else if (m_st == 0) begin
      if (l && !r) begin
        if (m_pos == 8) begin m_sl++; m_w = 2; m_cnt = 3; m_st = (m_sl == 7) ? 2 : 1; end
        else m_pos++;
      end else if (r && !l) begin
        if (m_pos == 0) begin m_sr++; m_w = 1; m_cnt = 3; m_st = (m_sr == 7) ? 2 : 1; end
        else m_pos--;
      end
    end else if (m_st == 1) begin
      if (m_cnt == 0) begin m_st = 0; m_pos = 4; m_w = 0; end
      else m_cnt--;
    end
    e.leds = (m_st == 0) ? (9'd1 << m_pos) : (m_w == 2 ? 9'h100 : 9'h001);
    e.w = 2'(m_w);
    e.sl = 3'(m_sl);
    e.sr = 3'(m_sr);
    e.go = m_st == 2;
    q.push_back(e);
  endtask

  task automatic step(input logic l, input logic r, input logic rs);
    exp_t e, g;
    @(negedge clk);
    L = l; R = r; reset = rs;
    model(l, r, rs);
    @(posedge clk);
    #1;
    L = 1'b0; R = 1'b0; reset = 1'b0;
    e = q.pop_front();
    g = {leds, winner, score_l, score_r, game_over};
    check("scoreboard", 32'(g), 32'(e));
  endtask

  initial begin
    step(0, 0, 1);
    repeat (3) step(0, 0, 0);
    check("reset_leds", 32'(leds), 32'(9'b000010000));
    check("reset_win", 32'(winner), 32'd0);
    check("reset_scores", 32'({score_l, score_r, game_over}), 32'd0);
    repeat (4) begin step(1, 0, 0); step(0, 0, 0); end
    check("left_end", 32'(leds), 32'(9'b100000000));
    step(1, 0, 0);
    check("lwin_leds", 32'(leds), 32'(9'b100000000));
    check("lwin_winner", 32'(winner), 32'b10);
    check("lwin_score", 32'(score_l), 32'd1);
    repeat (4) step(0, 0, 0);
    check("recentre_leds", 32'(leds), 32'(9'b000010000));
    check("recentre_win", 32'(winner), 32'd0);
    step(1, 1, 0);
    check("both_leds", 32'(leds), 32'(9'b000010000));
    check("both_score", 32'(score_l), 32'd1);
    repeat (5) step(0, 1, 0);
    check("rwin_score", 32'(score_r), 32'd1);
    check("rwin_leds", 32'(leds), 32'(9'b000000001));
    repeat (4) step(1, 0, 0);
    check("ignore_sl", 32'(score_l), 32'd1);
    check("ignore_leds", 32'(leds), 32'(9'b000010000));
    step(1, 0, 0);
    check("first_accept", 32'(leds), 32'(9'b000100000));
    for (int i = 0; i < 80; i++) step(0, 1, 0);
    check("over_sr", 32'(score_r), 32'd7);
    check("over_go", 32'(game_over), 32'd1);
    check("over_leds", 32'(leds), 32'(9'b000000001));
    check("over_win", 32'(winner), 32'b01);
    for (int i = 0; i < 6; i++) step(i[0], ~i[0], 0);
    check("over_hold", 32'({score_l, score_r, winner, game_over}), 32'({3'd1, 3'd7, 2'b01, 1'b1}));
    step(1, 1, 1);
    check("over_reset", 32'({leds, winner, score_l, score_r, game_over}), 32'({9'b000010000, 2'b00, 3'd0, 3'd0, 1'b0}));
    repeat (5) step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    check("midwin_reset", 32'({leds, winner, score_l, score_r, game_over}), 32'({9'b000010000, 2'b00, 3'd0, 3'd0, 1'b0}));
    step(0, 1, 0);
    check("after_reset_move", 32'(leds), 32'(9'b000001000));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tug_playfield.md
# tug_playfield

Game-core stage of the Tug of War design. It sits directly downstream of the per-player input conditioners and consumes their one-cycle press pulses. It moves a single lit position along an LED bar, detects when a player pushes the light off their end, and scores the round. It then holds the result, re-centres for the next round, and latches a final winner once a player reaches the match score.

## Interface
Parameters:
- N_POS, 9: number of bar positions; odd, ≥3; centre index C = (N_POS-1)/2
- HOLD_CYCLES, 4: cycles the round-win display is held before re-centring; ≥1
- SCORE_MAX, 7: round wins needed to end the match; ≥1
- Score width SW = $clog2(SCORE_MAX+1)

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high; sampled on posedge clk
- L  in  1  left-player press pulse, one cycle wide, from the input conditioner
- R  in  1  right-player press pulse, one cycle wide, from the input conditioner
- leds  out  N_POS  bar drive; leds[N_POS-1] is the left end, leds[0] is the right end
- winner  out  2  00 none, 10 left, 01 right; 11 never driven
- score_l  out  SW  left round wins
- score_r  out  SW  right round wins
- game_over  out  1  high once either score reaches SCORE_MAX

## Operation
- States: PLAY, WIN, OVER. Reset state is PLAY.
- Reset values: pos = C; leds = one-hot at C; winner = 00; score_l = score_r = 0; game_over = 0; hold counter = 0.
- PLAY:
  - L only: if pos < N_POS-1, then pos+1. If pos == N_POS-1, left wins the round.
  - R only: if pos > 0, then pos-1. If pos == 0, right wins the round.
  - L and R in the same cycle: no move and no win.
  - Neither input: hold.
  - leds is one-hot at pos.
- Round win (in PLAY):
  - Increment the winner's score.
  - Set winner.
  - Load the hold counter with HOLD_CYCLES-1.
  - Next state is OVER if the new score == SCORE_MAX, otherwise WIN.
- WIN:
  - leds shows only the winner's end LED: leds[N_POS-1] for left, leds[0] for right.
  - L and R are ignored.
  - The counter decrements each cycle.
  - On the cycle the counter reads 0: next state PLAY, pos = C, winner = 00.
- OVER:
  - leds shows the winner's end LED, winner is held, and game_over = 1.
  - All inputs are ignored until reset.
- Scores never exceed SCORE_MAX. The increment happens exactly once per round win.
- All outputs are registered; there are no combinational paths from L/R to outputs.

## Timing
- A press pulse high at posedge k takes effect at edge k: the new leds, winner and scores are visible after edge k, with 1-cycle latency from the sample edge.
- Win entered at edge k:
  - WIN occupies the cycles after edges k … k+HOLD_CYCLES-1.
  - At edge k+HOLD_CYCLES the block is in PLAY with leds one-hot at C and winner = 00.
  - A pulse at edge k+HOLD_CYCLES is ignored because the block is still in WIN when sampled. The first accepted pulse is at edge k+HOLD_CYCLES+1.
- game_over rises at the same edge as the final score increment.
- Reset has priority over every other event, including a simultaneous L/R pulse and mid-WIN or OVER. It restores all reset values at that edge.
- Back-to-back pulses on consecutive cycles each move one position.

## Test plan
- Reset then idle 3 cycles -> leds = 9'b000010000, winner = 00, scores = 0, game_over = 0.
- Four single-cycle L pulses, spaced 2 cycles apart -> leds ends at 9'b100000000. A fifth L pulse -> leds = 9'b100000000, winner = 10, score_l = 1. After 4 more edges -> leds = 9'b000010000, winner = 00.
- From centre, L and R high on the same cycle -> leds unchanged at 9'b000010000, no score change.
- Right wins a round, then L pulses during every WIN cycle -> all ignored; score_l unchanged; re-centres on schedule at k+4.
- Drive 7 right round wins -> score_r = 7, game_over = 1, leds = 9'b000000001, winner = 01. Further L/R pulses cause no change. Reset -> all reset values.
- Assert reset during WIN, on the second hold cycle -> next edge gives PLAY, leds centred, scores 0, winner 00. The next R pulse moves to 9'b000001000.
